// File: rtl/core_pipe.sv
`default_nettype none
// ============================================================================
// Module   : core_pipe
// Purpose  : 3-stage pipelined core (fetch / decode-execute / writeback) with
//            S3->S2 forwarding, taken-branch flush, external stall and HALT.
// Revision : 1.0 - initial release
// ============================================================================
module core_pipe #(
    parameter int DATA_W = 8,
    parameter int RA     = 4,
    parameter int PC_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [4+3*RA-1:0]       instraction,
    output logic [PC_W-1:0]         pc,
    output logic [DATA_W-1:0]       core_out,
    output logic                    wb_valid,
    output logic [RA-1:0]           wb_addr,
    output logic                    halted
);

    localparam int c_INST_W = 4 + 3*RA;
    localparam int c_NREG   = 2**RA;

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_AND  = 4'h2;
    localparam logic [3:0] c_OP_OR   = 4'h3;
    localparam logic [3:0] c_OP_XOR  = 4'h4;
    localparam logic [3:0] c_OP_SHL  = 4'h5;
    localparam logic [3:0] c_OP_SHR  = 4'h6;
    localparam logic [3:0] c_OP_SLT  = 4'h7;
    localparam logic [3:0] c_OP_LI   = 4'h8;
    localparam logic [3:0] c_OP_ADDI = 4'h9;
    localparam logic [3:0] c_OP_JMP  = 4'hA;
    localparam logic [3:0] c_OP_BEQZ = 4'hB;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    localparam logic [c_INST_W-1:0] c_NOP = {4'hC, {(3*RA){1'b0}}};

    logic [PC_W-1:0]     r_pc;
    logic [c_INST_W-1:0] r_ir;
    logic [DATA_W-1:0]   r_core_out;
    logic                r_wb_valid;
    logic [RA-1:0]       r_wb_addr;
    logic                r_halted;
    logic [DATA_W-1:0]   r_regs [c_NREG];

    logic [3:0]          w_op;
    logic [RA-1:0]       w_rd;
    logic [RA-1:0]       w_rs1;
    logic [RA-1:0]       w_rs2;
    logic [DATA_W-1:0]   w_imm;
    logic [PC_W-1:0]     w_target;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_d;
    logic [DATA_W-1:0]   w_result;
    logic                w_writes;
    logic                w_taken;
    logic                w_halt;
    logic                w_en;

    assign w_op     = r_ir[c_INST_W-1 -: 4];
    assign w_rd     = r_ir[c_INST_W-5 -: RA];
    assign w_rs1    = r_ir[c_INST_W-5-RA -: RA];
    assign w_rs2    = r_ir[RA-1:0];
    assign w_imm    = DATA_W'(r_ir[2*RA-1:0]);
    assign w_target = PC_W'(r_ir[2*RA-1:0]);

    // Operands come from S3 when it is about to write the same register.
    assign w_a = (r_wb_valid && (r_wb_addr == w_rs1)) ? r_core_out : r_regs[w_rs1];
    assign w_b = (r_wb_valid && (r_wb_addr == w_rs2)) ? r_core_out : r_regs[w_rs2];
    assign w_d = (r_wb_valid && (r_wb_addr == w_rd))  ? r_core_out : r_regs[w_rd];

    always_comb begin
        w_result = '0;
        w_writes = 1'b0;
        w_taken  = 1'b0;
        w_halt   = 1'b0;
        case (w_op)
            c_OP_ADD:  begin w_result = w_a + w_b;              w_writes = 1'b1; end
            c_OP_SUB:  begin w_result = w_a - w_b;              w_writes = 1'b1; end
            c_OP_AND:  begin w_result = w_a & w_b;              w_writes = 1'b1; end
            c_OP_OR:   begin w_result = w_a | w_b;              w_writes = 1'b1; end
            c_OP_XOR:  begin w_result = w_a ^ w_b;              w_writes = 1'b1; end
            c_OP_SHL:  begin w_result = w_a << w_b[2:0];        w_writes = 1'b1; end
            c_OP_SHR:  begin w_result = w_a >> w_b[2:0];        w_writes = 1'b1; end
            c_OP_SLT:  begin w_result = DATA_W'(w_a < w_b);     w_writes = 1'b1; end
            c_OP_LI:   begin w_result = w_imm;                  w_writes = 1'b1; end
            c_OP_ADDI: begin w_result = w_d + w_imm;            w_writes = 1'b1; end
            c_OP_JMP:  w_taken = 1'b1;
            c_OP_BEQZ: w_taken = (w_d == '0);
            c_OP_HALT: w_halt  = 1'b1;
            default:   ;
        endcase
    end

    // Once halted the stall input no longer matters; S3 still drains.
    assign w_en = !stall || r_halted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= '0;
            r_ir       <= c_NOP;
            r_core_out <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_halted   <= 1'b0;
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_en) begin
            if (r_wb_valid) begin
                r_regs[r_wb_addr] <= r_core_out;
            end
            r_core_out <= w_result;
            r_wb_addr  <= w_rd;
            r_wb_valid <= w_writes;
            if (r_halted || w_halt) begin
                r_halted <= 1'b1;
                r_ir     <= c_NOP;
            end else if (w_taken) begin
                r_pc <= w_target;
                r_ir <= c_NOP;
            end else begin
                r_pc <= r_pc + PC_W'(1);
                r_ir <= instraction;
            end
        end
    end

    assign pc       = r_pc;
    assign core_out = r_core_out;
    assign wb_valid = r_wb_valid;
    assign wb_addr  = r_wb_addr;
    assign halted   = r_halted;

endmodule
`default_nettype wire
